// File: rtl/instr_fetch_pkg.sv
// instr_fetch_pkg
// Shared CPU package: fetch FSM state encoding, the default reset PC and the
// bit positions of the instruction-register fields. The control decoder
// imports the same field positions so both sides agree on the IR layout.
package instr_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int RS_MSB     = 25;
  localparam int RS_LSB     = 21;
  localparam int RT_MSB     = 20;
  localparam int RT_LSB     = 16;
  localparam int RD_MSB     = 15;
  localparam int RD_LSB     = 11;
  localparam int FUNCT_MSB  = 5;
  localparam int FUNCT_LSB  = 0;
  localparam int IMM_MSB    = 15;
  localparam int IMM_LSB    = 0;
  localparam int TARGET_MSB = 25;
  localparam int TARGET_LSB = 0;

  // Branch offset: word offset sign-extended and turned into a byte offset.
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_npc_calc.sv
// npc_calc
// Combinational next-PC select used when the IR is consumed.
// Ports:
//   pc       in  32  address of the instruction being consumed
//   target26 in  26  jump target field of that instruction
//   imm16    in  16  branch offset field of that instruction
//   jump     in   1  take the jump target (wins over Branch)
//   Branch   in   1  conditional branch, taken only when zero=1
//   zero     in   1  ALU zero flag
//   npc      out 32  next fetch address (all arithmetic wraps modulo 2^32)
module npc_calc
  import instr_fetch_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [25:0] target26,
  input  logic [15:0] imm16,
  input  logic        jump,
  input  logic        Branch,
  input  logic        zero,
  output logic [31:0] npc
);

  logic [31:0] pc_plus4;

  always_comb begin
    pc_plus4 = pc + 32'd4;
    npc      = pc_plus4;
    if (jump) begin
      npc = {pc_plus4[31:28], target26, 2'b00};
    end else if (Branch && zero) begin
      npc = pc_plus4 + branch_offset(imm16);
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch
// Instruction fetch unit with a single instruction register and no prefetch:
// a word is requested (REQ), held in the IR until the datapath consumes it
// (HOLD), then the next address from npc_calc is requested.
// Ports:
//   clk, rst_n           clock (rising edge), async active-low reset
//   imem_req/imem_addr   read request and word-aligned address (REQ only)
//   imem_ack/imem_rdata  memory response, honoured only in REQ
//   ir_valid/ir_ready    IR handshake; consume = ir_valid && ir_ready
//   OpCode..target26     IR fields, meaningful only while ir_valid=1
//   jump/Branch/zero     next-PC controls, sampled at consume
//   pc                   address of the instruction in the IR
//   instr_cnt            number of consumed instructions (wraps)
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        ir_valid,
  input  logic        ir_ready,
  output logic [5:0]  OpCode,
  output logic [5:0]  funct,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [15:0] imm16,
  output logic [25:0] target26,
  input  logic        jump,
  input  logic        Branch,
  input  logic        zero,
  output logic [31:0] pc,
  output logic [15:0] instr_cnt
);

  fetch_state_e state, state_nx;
  logic [31:0]  fetch_pc;
  logic [31:0]  pc_q;
  logic [31:0]  ir;
  logic [15:0]  cnt_q;
  logic [31:0]  npc;
  logic         take_ack;
  logic         consume;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // imem_req and ir_valid are decoded from mutually exclusive states, so a
  // request can never overlap a valid IR.
  always_comb begin
    state_nx = state;
    imem_req = 1'b0;
    ir_valid = 1'b0;
    take_ack = 1'b0;
    consume  = 1'b0;
    case (state)
      IDLE: state_nx = REQ;
      REQ: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          take_ack = 1'b1;
          state_nx = HOLD;
        end
      end
      HOLD: begin
        ir_valid = 1'b1;
        if (ir_ready) begin
          consume  = 1'b1;
          state_nx = REQ;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  npc_calc u_npc_calc (
    .pc       (pc_q),
    .target26 (ir[TARGET_MSB:TARGET_LSB]),
    .imm16    (ir[IMM_MSB:IMM_LSB]),
    .jump     (jump),
    .Branch   (Branch),
    .zero     (zero),
    .npc      (npc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
      pc_q     <= RESET_PC;
      ir       <= 32'h0;
      cnt_q    <= 16'h0;
    end else if (take_ack) begin
      ir   <= imem_rdata;
      pc_q <= fetch_pc;
    end else if (consume) begin
      fetch_pc <= npc;
      cnt_q    <= cnt_q + 16'd1;
    end
  end

  assign imem_addr = {fetch_pc[31:2], 2'b00};
  assign pc        = pc_q;
  assign instr_cnt = cnt_q;
  assign OpCode    = ir[OPCODE_MSB:OPCODE_LSB];
  assign funct     = ir[FUNCT_MSB:FUNCT_LSB];
  assign rs        = ir[RS_MSB:RS_LSB];
  assign rt        = ir[RT_MSB:RT_LSB];
  assign rd        = ir[RD_MSB:RD_LSB];
  assign imm16     = ir[IMM_MSB:IMM_LSB];
  assign target26  = ir[TARGET_MSB:TARGET_LSB];

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch
// Directed bench for instr_fetch. The stimulus process plays memory and
// decoder and pushes the expected fetch addresses and IR contents into
// queues; the monitor pops them whenever the DUT starts a request or
// presents a new IR, and checks hold/stability behaviour every cycle.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        ir_valid;
  logic        ir_ready = 1'b0;
  logic [5:0]  OpCode;
  logic [5:0]  funct;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm16;
  logic [25:0] target26;
  logic        jump = 1'b0;
  logic        Branch = 1'b0;
  logic        zero = 1'b0;
  logic [31:0] pc;
  logic [15:0] instr_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] word;
    logic [31:0] pc;
    logic [15:0] cnt;
  } irexp_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  delay;
    logic [3:0]  stall;
    logic        j;
    logic        b;
    logic        z;
    logic        fc;
    logic [31:0] pc;
    logic [15:0] cnt;
    logic [31:0] nxt;
  } vec_t;

  irexp_t      irQ[$];
  logic [31:0] addrQ[$];

  always #5 clk = ~clk;

  instr_fetch #(.RESET_PC(32'h0000_3000)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .ir_valid   (ir_valid),
    .ir_ready   (ir_ready),
    .OpCode     (OpCode),
    .funct      (funct),
    .rs         (rs),
    .rt         (rt),
    .rd         (rd),
    .imm16      (imm16),
    .target26   (target26),
    .jump       (jump),
    .Branch     (Branch),
    .zero       (zero),
    .pc         (pc),
    .instr_cnt  (instr_cnt)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic checkFields(input irexp_t e);
    logic [31:0] w;
    w = e.word;
    checkOutput("opcode", 32'(OpCode), 32'(w[31:26]));
    checkOutput("funct", 32'(funct), 32'(w[5:0]));
    checkOutput("rs", 32'(rs), 32'(w[25:21]));
    checkOutput("rt", 32'(rt), 32'(w[20:16]));
    checkOutput("rd", 32'(rd), 32'(w[15:11]));
    checkOutput("imm16", 32'(imm16), 32'(w[15:0]));
    checkOutput("target26", 32'(target26), 32'(w[25:0]));
    checkOutput("ir_pc", pc, e.pc);
    checkOutput("instr_cnt", 32'(instr_cnt), 32'(e.cnt));
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  logic   prevReq = 1'b0;
  logic   prevValid = 1'b0;
  logic   [31:0] curAddr = 32'h0;
  irexp_t curIr = '0;

  always @(posedge clk) begin
    logic ackTaken, consumed;
    #1;
    if (!rst_n) begin
      checkOutput("reset_req", 32'(imem_req), 32'd0);
      checkOutput("reset_valid", 32'(ir_valid), 32'd0);
      prevReq   = 1'b0;
      prevValid = 1'b0;
    end else begin
      ackTaken = prevReq && imem_ack;
      consumed = prevValid && ir_ready;
      checkOutput("req_valid_excl", 32'(imem_req & ir_valid), 32'd0);
      if (imem_req && !prevReq) begin
        if (addrQ.size() == 0) begin
          checkOutput("unexpected_fetch", imem_addr, 32'hFFFF_FFFF);
        end else begin
          curAddr = addrQ.pop_front();
          checkOutput("fetch_addr", imem_addr, curAddr);
        end
      end else if (imem_req) begin
        checkOutput("addr_stable", imem_addr, curAddr);
      end
      if (ackTaken) begin
        checkOutput("valid_latency", 32'(ir_valid), 32'd1);
        if (irQ.size() == 0) begin
          checkOutput("unexpected_ir", 32'(ir_valid), 32'd0);
        end else begin
          curIr = irQ.pop_front();
          checkFields(curIr);
        end
      end else if (prevValid && !consumed) begin
        checkOutput("hold_valid", 32'(ir_valid), 32'd1);
        checkFields(curIr);
      end else if (consumed) begin
        checkOutput("valid_drop", 32'(ir_valid), 32'd0);
        checkOutput("refetch_req", 32'(imem_req), 32'd1);
      end else begin
        checkOutput("no_spurious_valid", 32'(ir_valid), 32'd0);
      end
      prevReq   = imem_req;
      prevValid = ir_valid;
    end
  end

  task automatic waitReq();
    int n = 0;
    while (!imem_req && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!imem_req) checkOutput("req_timeout", 32'(imem_req), 32'd1);
  endtask

  function automatic vec_t mk(input logic [31:0] data, input logic [3:0] delay, input logic [3:0] stall,
                              input logic j, input logic b, input logic z, input logic fc,
                              input logic [31:0] vpc, input logic [15:0] cnt, input logic [31:0] nxt);
    vec_t v;
    v.data = data; v.delay = delay; v.stall = stall;
    v.j = j; v.b = b; v.z = z; v.fc = fc;
    v.pc = vpc; v.cnt = cnt; v.nxt = nxt;
    return v;
  endfunction

  // One instruction: answer the request, stall with stray controls and
  // stray acks, then consume with the vector's jump/Branch/zero.
  task automatic applyStimulus(input vec_t v);
    irQ.push_back('{word: v.data, pc: v.pc, cnt: v.cnt});
    waitReq();
    if (v.fc) begin
      force dut.cnt_q = 16'hFFFF;
      @(negedge clk);
      release dut.cnt_q;
    end
    repeat (v.delay) @(negedge clk);
    imem_ack   = 1'b1;
    imem_rdata = v.data;
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < int'(v.stall); i++) begin
      jump       = i[0];
      Branch     = 1'b1;
      zero       = 1'b1;
      imem_ack   = 1'b1;
      imem_rdata = 32'hBAD0_0000 + i;
      @(negedge clk);
    end
    imem_ack = 1'b0;
    jump     = v.j;
    Branch   = v.b;
    zero     = v.z;
    ir_ready = 1'b1;
    addrQ.push_back(v.nxt);
    @(negedge clk);
    ir_ready = 1'b0;
    jump     = 1'b0;
    Branch   = 1'b0;
    zero     = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: time limit reached, errors so far %0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (2) @(negedge clk);
    checkOutput("rst_req", 32'(imem_req), 32'd0);
    checkOutput("rst_valid", 32'(ir_valid), 32'd0);
    checkOutput("rst_addr", imem_addr, 32'h0000_3000);
    checkOutput("rst_pc", pc, 32'h0000_3000);
    checkOutput("rst_cnt", 32'(instr_cnt), 32'd0);
    checkOutput("rst_opcode", 32'(OpCode), 32'd0);
    addrQ.push_back(32'h0000_3000);
    rst_n = 1'b1;

    //                data          dly   stl   j     b     z     fc    pc            cnt       next
    applyStimulus(mk(32'h2008_0005, 4'd1, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_3000, 16'd0,    32'h0000_3004));
    applyStimulus(mk(32'h2009_0003, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_3004, 16'd1,    32'h0000_3008));
    applyStimulus(mk(32'h1000_0001, 4'd2, 4'd1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_3008, 16'd2,    32'h0000_3010));
    applyStimulus(mk(32'h1000_FFFF, 4'd0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_3010, 16'd3,    32'h0000_3010));
    applyStimulus(mk(32'h1000_FFFF, 4'd0, 4'd2, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_3010, 16'd4,    32'h0000_3014));
    applyStimulus(mk(32'h0C00_0C10, 4'd1, 4'd0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_3014, 16'd5,    32'h0000_3040));
    applyStimulus(mk(32'h1000_8000, 4'd0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_3040, 16'd6,    32'hFFFE_3044));
    applyStimulus(mk(32'h0BFF_FFFF, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFE_3044, 16'd7,    32'hFFFF_FFFC));
    applyStimulus(mk(32'h0000_0020, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 16'hFFFF, 32'h0000_0000));
    applyStimulus(mk(32'h0123_4567, 4'd0, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 16'd0,    32'h0000_0004));

    // Reset in the middle of an outstanding request, with a stray ack.
    waitReq();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midreq_req_drop", 32'(imem_req), 32'd0);
    checkOutput("midreq_valid", 32'(ir_valid), 32'd0);
    checkOutput("midreq_addr", imem_addr, 32'h0000_3000);
    checkOutput("midreq_cnt", 32'(instr_cnt), 32'd0);
    @(negedge clk);
    imem_ack   = 1'b1;
    imem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    addrQ.push_back(32'h0000_3000);
    rst_n = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0;

    applyStimulus(mk(32'h0800_0C10, 4'd0, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_3000, 16'd0,    32'h0000_3040));
    applyStimulus(mk(32'h0000_0000, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_3040, 16'd1,    32'h0000_3044));

    for (int n = 0; n < 20 && addrQ.size() != 0; n++) @(negedge clk);
    repeat (2) @(negedge clk);
    checkOutput("addr_queue_drained", 32'(addrQ.size()), 32'd0);
    checkOutput("ir_queue_drained", 32'(irQ.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
